// File: rtl/reduction_handshake_stage.sv
// Three-way round-robin arbiter feeding a small FIFO of {word, |word, &word, source}.
// The FIFO head drains through one valid/ready channel; out = orr && andr of the head.
module reduction_handshake_stage #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic             handshake_arr_0_valid,
    input  logic             handshake_arr_1_valid,
    input  logic             handshake_arr_2_valid,
    output logic             handshake_arr_0_ready,
    output logic             handshake_arr_1_ready,
    output logic             handshake_arr_2_ready,
    input  logic [WIDTH-1:0] in_0,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    output logic             handshake_valid,
    input  logic             handshake_ready,
    output logic [WIDTH-1:0] in1,
    output logic             orr,
    output logic             andr,
    output logic             out,
    output logic [1:0]       src,
    output logic [7:0]       xfer_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_word [DEPTH];
    logic             r_orr  [DEPTH];
    logic             r_andr [DEPTH];
    logic [1:0]       r_src  [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [1:0]       r_rr;
    logic [7:0]       r_xfer;

    logic [2:0]       w_valid;
    logic [2:0]       w_grant;
    logic [1:0]       w_gidx;
    logic [1:0]       w_o0;
    logic [1:0]       w_o1;
    logic [1:0]       w_o2;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [WIDTH-1:0] w_word;

    assign w_valid = {handshake_arr_2_valid, handshake_arr_1_valid, handshake_arr_0_valid};
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && handshake_ready;

    // Priority rotates to start just after the last winner; grant uses registered full only.
    always_comb begin
        w_o0    = (r_rr == 2'd2) ? 2'd0 : r_rr + 2'd1;
        w_o1    = (w_o0 == 2'd2) ? 2'd0 : w_o0 + 2'd1;
        w_o2    = (w_o1 == 2'd2) ? 2'd0 : w_o1 + 2'd1;
        w_gidx  = r_rr;
        w_push  = 1'b0;
        w_grant = '0;
        if (!w_full && !ASYNCRESET) begin
            if (w_valid[w_o0]) begin
                w_gidx = w_o0;
                w_push = 1'b1;
            end else if (w_valid[w_o1]) begin
                w_gidx = w_o1;
                w_push = 1'b1;
            end else if (w_valid[w_o2]) begin
                w_gidx = w_o2;
                w_push = 1'b1;
            end
        end
        if (w_push) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    always_comb begin
        case (w_gidx)
            2'd0:    w_word = in_0;
            2'd1:    w_word = in_1;
            default: w_word = in_2;
        endcase
    end

    assign handshake_arr_0_ready = w_grant[0];
    assign handshake_arr_1_ready = w_grant[1];
    assign handshake_arr_2_ready = w_grant[2];

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_word[i] <= '0;
                r_orr[i]  <= 1'b0;
                r_andr[i] <= 1'b0;
                r_src[i]  <= 2'd0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_rr    <= 2'd2;
            r_xfer  <= 8'd0;
        end else begin
            if (w_push) begin
                r_word[r_wptr] <= w_word;
                r_orr[r_wptr]  <= |w_word;
                r_andr[r_wptr] <= &w_word;
                r_src[r_wptr]  <= w_gidx;
                r_wptr         <= r_wptr + AW'(1);
                r_rr           <= w_gidx;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
                r_xfer <= r_xfer + 8'd1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign handshake_valid = !w_empty;
    assign in1             = r_word[r_rptr];
    assign orr             = r_orr[r_rptr];
    assign andr            = r_andr[r_rptr];
    assign out             = r_orr[r_rptr] && r_andr[r_rptr];
    assign src             = r_src[r_rptr];
    assign xfer_count      = r_xfer;

endmodule

// File: tb/tb_reduction_handshake_stage.sv
// Bench for reduction_handshake_stage: directed scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_reduction_handshake_stage;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;

    logic             CLK = 1'b0;
    logic             ASYNCRESET;
    logic             v0, v1, v2;
    logic             r0, r1, r2;
    logic [WIDTH-1:0] d0, d1, d2;
    logic             handshake_valid;
    logic             handshake_ready;
    logic [WIDTH-1:0] in1;
    logic             orr, andr, out;
    logic [1:0]       src;
    logic [7:0]       xfer_count;

    int n_vec = 0;
    int n_err = 0;

    int q_word[$];
    int q_src[$];
    int m_rr   = 2;
    int m_xfer = 0;

    reduction_handshake_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK                   (CLK),
        .ASYNCRESET            (ASYNCRESET),
        .handshake_arr_0_valid (v0),
        .handshake_arr_1_valid (v1),
        .handshake_arr_2_valid (v2),
        .handshake_arr_0_ready (r0),
        .handshake_arr_1_ready (r1),
        .handshake_arr_2_ready (r2),
        .in_0                  (d0),
        .in_1                  (d1),
        .in_2                  (d2),
        .handshake_valid       (handshake_valid),
        .handshake_ready       (handshake_ready),
        .in1                   (in1),
        .orr                   (orr),
        .andr                  (andr),
        .out                   (out),
        .src                   (src),
        .xfer_count            (xfer_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_word.delete();
        q_src.delete();
        m_rr   = 2;
        m_xfer = 0;
    endtask

    // Called at posedge+1: drive, check mid-cycle, advance model across the next edge.
    task automatic step(input logic [2:0] v, input logic [3:0] w0, input logic [3:0] w1,
                        input logic [3:0] w2, input logic rdy);
        int g;
        int idx;
        int w;
        logic [1:0] ix;
        v0 = v[0]; v1 = v[1]; v2 = v[2];
        d0 = w0;   d1 = w1;   d2 = w2;
        handshake_ready = rdy;
        #2;
        g = -1;
        if (q_word.size() < DEPTH) begin
            for (int k = 0; k < 3; k++) begin
                idx = (m_rr + 1 + k) % 3;
                ix  = 2'(idx);
                if (g < 0 && v[ix]) g = idx;
            end
        end
        check("ready0", 32'(r0), 32'(g == 0));
        check("ready1", 32'(r1), 32'(g == 1));
        check("ready2", 32'(r2), 32'(g == 2));
        check("hvalid", 32'(handshake_valid), 32'(q_word.size() > 0));
        if (q_word.size() > 0) begin
            check("in1",  32'(in1),  32'(q_word[0]));
            check("orr",  32'(orr),  32'(q_word[0] != 0));
            check("andr", 32'(andr), 32'(q_word[0] == 15));
            check("out",  32'(out),  32'(q_word[0] == 15));
            check("src",  32'(src),  32'(q_src[0]));
        end
        check("xfer", 32'(xfer_count), 32'(m_xfer));
        @(posedge CLK);
        if (q_word.size() > 0 && rdy) begin
            void'(q_word.pop_front());
            void'(q_src.pop_front());
            m_xfer = (m_xfer + 1) % 256;
        end
        if (g >= 0) begin
            w = (g == 0) ? int'(w0) : (g == 1) ? int'(w1) : int'(w2);
            q_word.push_back(w);
            q_src.push_back(g);
            m_rr = g;
        end
        #1;
    endtask

    // Reset between edges, check immediate effect, release before the next edge.
    task automatic mid_reset();
        v0 = 1'b1; v1 = 1'b1; v2 = 1'b1;
        handshake_ready = 1'b0;
        ASYNCRESET = 1'b1;
        #1;
        check("rst_hvalid", 32'(handshake_valid), 32'd0);
        check("rst_xfer",   32'(xfer_count), 32'd0);
        check("rst_ready",  32'({r2, r1, r0}), 32'd0);
        check("rst_in1",    32'(in1), 32'd0);
        check("rst_src",    32'(src), 32'd0);
        model_reset();
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        @(negedge CLK);
        ASYNCRESET = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [3:0] rw();
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        ASYNCRESET = 1'b1;
        v0 = 1'b1; v1 = 1'b1; v2 = 1'b1;
        d0 = '0; d1 = '0; d2 = '0;
        handshake_ready = 1'b0;
        #2;
        check("por_hvalid", 32'(handshake_valid), 32'd0);
        check("por_ready",  32'({r2, r1, r0}), 32'd0);
        check("por_xfer",   32'(xfer_count), 32'd0);
        check("por_out",    32'(out), 32'd0);
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        @(posedge CLK);
        #1;
        ASYNCRESET = 1'b0;

        // single push on ch1
        step(3'b010, 4'h0, 4'hF, 4'h0, 1'b0);
        step(3'b000, 4'h0, 4'h0, 4'h0, 1'b0);
        step(3'b000, 4'h0, 4'h0, 4'h0, 1'b1);

        // round-robin with all channels valid
        for (int i = 0; i < 6; i++) step(3'b111, rw(), rw(), rw(), 1'b1);
        for (int i = 0; i < 3; i++) step(3'b000, 4'h0, 4'h0, 4'h0, 1'b1);

        // full / backpressure on ch0
        step(3'b001, 4'h1, 4'h0, 4'h0, 1'b0);
        step(3'b001, 4'h0, 4'h0, 4'h0, 1'b0);
        step(3'b001, 4'h3, 4'h0, 4'h0, 1'b0);
        step(3'b001, 4'h3, 4'h0, 4'h0, 1'b1);
        step(3'b001, 4'h3, 4'h0, 4'h0, 1'b1);
        for (int i = 0; i < 3; i++) step(3'b000, 4'h0, 4'h0, 4'h0, 1'b1);

        // simultaneous push/pop at count 1
        step(3'b001, 4'h5, 4'h0, 4'h0, 1'b0);
        step(3'b100, 4'h0, 4'h0, 4'hA, 1'b1);
        step(3'b000, 4'h0, 4'h0, 4'h0, 1'b0);
        step(3'b000, 4'h0, 4'h0, 4'h0, 1'b1);

        // async reset with two entries buffered, then all channels valid
        step(3'b010, 4'h7, 4'h7, 4'h0, 1'b0);
        step(3'b010, 4'h7, 4'h8, 4'h0, 1'b0);
        mid_reset();
        step(3'b111, 4'h2, 4'h4, 4'h6, 1'b0);
        check("post_rst_src", 32'(src), 32'd0);
        step(3'b000, 4'h0, 4'h0, 4'h0, 1'b1);

        // xfer_count wrap after 256 handshakes from a fresh reset
        mid_reset();
        for (int i = 0; i < 257; i++) step(3'b001, rw(), 4'h0, 4'h0, 1'b1);
        step(3'b000, 4'h0, 4'h0, 4'h0, 1'b0);
        check("wrap_xfer", 32'(xfer_count), 32'd0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(3'($urandom_range(0, 7)), rw(), rw(), rw(), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reduction_handshake_stage.md
# reduction_handshake_stage

Upstream producer for the handshake-monitored RTL datapath. Round-robin arbitrates three valid/ready input channels of 4-bit words, computes the OR- and AND-reductions of the winning word, and buffers the result in a DEPTH-entry FIFO. The FIFO drains through a single valid/ready output channel. The output contract is `out == (orr && andr)` whenever `handshake_valid` is high, which is the property the downstream monitor asserts.

## Interface
Parameters:
- WIDTH, 4, data word width (≥2)
- DEPTH, 2, FIFO entries (power of two, ≥2)

Ports:
- CLK  input  1  clock, rising edge
- ASYNCRESET  input  1  asynchronous, active-high reset
- handshake_arr_i_valid (i=0..2)  input  1  channel i word valid
- handshake_arr_i_ready (i=0..2)  output  1  channel i word accepted this cycle
- in_i (i=0..2)  input  WIDTH  channel i data word
- handshake_valid  output  1  FIFO head valid
- handshake_ready  input  1  downstream accepts head
- in1  output  WIDTH  head data word
- orr  output  1  |(head word)
- andr  output  1  &(head word)
- out  output  1  orr && andr of head
- src  output  2  channel index (0..2) that produced head
- xfer_count  output  8  completed output handshakes, wraps 255→0

One clock; reset is asynchronous and active-high.

## Operation
- Storage: DEPTH entries of {word, orr, andr, src}, plus write pointer, read pointer, and a count of log2(DEPTH)+1 bits.
- full = (count == DEPTH). empty = (count == 0).
- Arbiter:
  - rr_ptr holds the last granted index. Reset value is 2, so the first priority order is 0, 1, 2.
  - Search order starts at rr_ptr+1 mod 3. The first channel with valid high is granted.
  - Grant is allowed only when !full.
  - handshake_arr_i_ready = grant_i. At most one ready is high per cycle.
  - Ready may depend on valid. Valid must never depend on ready.
  - On grant, rr_ptr ← granted index. With no grant, rr_ptr holds.
- Push (grant): entry[wptr] ← {in_g, |in_g, &in_g, g}; wptr++ mod DEPTH.
- Pop (handshake_valid && handshake_ready): rptr++ mod DEPTH; xfer_count++ (wraps).
- Count update: push only → +1; pop only → −1; both → unchanged.
- Full with a pop in the same cycle: no push that cycle. Ready is computed from registered full, with no bypass.
- Outputs are driven from entry[rptr] and are don't-care while empty. handshake_valid = !empty.
- Head stability: once handshake_valid rises, in1/orr/andr/out/src must not change until the pop.
- Reductions are taken over all WIDTH bits of the word.
- Unused channel words produce no side effects.

## Timing
- Reset values (asynchronous, immediate): handshake_valid 0, all handshake_arr_i_ready 0 while reset is asserted, count 0, wptr 0, rptr 0, rr_ptr 2, xfer_count 0. in1/orr/andr/out/src read as 0 (storage cleared).
- Reset asserted mid-operation: all buffered words are discarded and handshake_valid drops in the same cycle.
- After reset deasserts, grants may occur in the first clock.
- Latency: a word accepted at edge N appears on the head at N+1 if the FIFO was empty.
- There is no combinational path from in_i or handshake_arr_i_valid to any output-channel signal.
- Throughput: with DEPTH ≥ 2 and handshake_ready held high, the stage sustains one word per cycle.
- Backpressure: after DEPTH consecutive pushes with no pop, all readies are low until the first pop edge. Ready reasserts in the cycle after that pop.

## Test plan
- Reset then single push: ch1 valid with in_1=4'hF, handshake_ready=0 → ready_1 high for one cycle; next cycle handshake_valid=1, in1=F, orr=1, andr=1, out=1, src=1.
- Round-robin fairness: all three channels held valid, handshake_ready=1 for 6 cycles → grant order 0,1,2,0,1,2; src sequence matches; xfer_count=6 after drain.
- Full/backpressure: ch0 valid with words 4'h1, 4'h0, 4'h3, handshake_ready=0 → two pushes, then ready_0=0. Assert handshake_ready → pops 1 (orr=1, andr=0, out=0), then 0 (orr=0, out=0). Word 3 is accepted in the cycle after the first pop.
- Simultaneous push/pop at count 1: ch2 valid with word 4'hA while head pops → count stays 1; the next head is A with src=2.
- Async reset mid-stream: assert ASYNCRESET between edges with 2 entries buffered → handshake_valid=0 immediately, xfer_count=0. The first post-reset grant goes to ch0 when all channels are valid.
- xfer_count wrap: 256 output handshakes → xfer_count returns to 0.
